// File: rtl/exc_ctrl.sv
// exc_ctrl: exception sequencer that saves EPC/Cause/Status to CP0 and redirects the PC.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h00400004,
  parameter int          NUM_INT      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               syscall,
  input  logic               breakc,
  input  logic               teq,
  input  logic               zero,
  input  logic               eret,
  input  logic [31:0]        pc,
  input  logic [NUM_INT-1:0] irq,
  input  logic [31:0]        status,
  input  logic [31:0]        epc,
  output logic               stall,
  output logic               cp0_we,
  output logic [4:0]         cp0_waddr,
  output logic [31:0]        cp0_wdata,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic [NUM_INT-1:0] irq_ack
);
  typedef enum logic [2:0] {IDLE, S_EPC, S_CAUSE, S_STAT, S_JUMP, R_STAT, R_JUMP} state_t;
  state_t             r_state;
  logic [31:0]        r_pc, r_status;
  logic [4:0]         r_code;
  logic [NUM_INT-1:0] r_line;
  logic               w_ge, w_sys, w_brk, w_tq, w_int, w_take;
  logic [NUM_INT-1:0] w_low;
  logic [31:0]        w_cause;
  assign w_ge   = status[0];
  assign w_sys  = syscall & w_ge & status[1];
  assign w_brk  = breakc & w_ge & status[2];
  assign w_tq   = teq & zero & w_ge & status[3];
  assign w_int  = (|irq) & w_ge;
  assign w_take = w_sys | w_brk | w_tq | w_int;
  // isolates the lowest set irq line
  assign w_low   = irq & (~irq + NUM_INT'(1));
  assign w_cause = (32'(r_line) << 8) | (32'(r_code) << 2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_status <= '0;
      r_code   <= '0;
      r_line   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (eret) r_state <= R_STAT;
          else if (w_take) begin
            r_state  <= S_EPC;
            r_pc     <= pc;
            r_status <= status;
            r_code   <= w_sys ? 5'b01000 : w_brk ? 5'b01001 : w_tq ? 5'b01101 : 5'b00000;
            r_line   <= (w_sys | w_brk | w_tq) ? '0 : w_low;
          end
        end
        S_EPC:   r_state <= S_CAUSE;
        S_CAUSE: r_state <= S_STAT;
        S_STAT:  r_state <= S_JUMP;
        R_STAT:  r_state <= R_JUMP;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign stall       = (r_state != IDLE) | eret | w_take;
  assign cp0_we      = r_state inside {S_EPC, S_CAUSE, S_STAT, R_STAT};
  assign cp0_waddr   = r_state == S_EPC ? 5'd14 : r_state == S_CAUSE ? 5'd13 :
                       (r_state == S_STAT || r_state == R_STAT) ? 5'd12 : 5'd0;
  assign cp0_wdata   = r_state == S_EPC ? r_pc : r_state == S_CAUSE ? w_cause :
                       r_state == S_STAT ? r_status << 4 : r_state == R_STAT ? status >> 4 : 32'd0;
  assign pc_redirect = r_state inside {S_JUMP, R_JUMP};
  assign pc_target   = r_state == S_JUMP ? HANDLER_ADDR : r_state == R_JUMP ? epc : 32'd0;
  assign irq_ack     = r_state == S_JUMP ? r_line : '0;
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench; stimulus queues expected CP0 writes/redirects, a monitor checks them.
module tb_exc_ctrl;
  logic        clk = 0, rst = 1;
  logic        syscall = 0, breakc = 0, teq = 0, zero = 0, eret = 0;
  logic [31:0] pc = 0, status = 0, epc = 0;
  logic [3:0]  irq = 0;
  logic        stall, cp0_we, pc_redirect;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata, pc_target;
  logic [3:0]  irq_ack;
  int vectors = 0, miscompares = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rd;
    logic [31:0] tgt;
    logic [3:0]  ack;
  } exp_t;
  exp_t q[$];

  exc_ctrl dut (
    .clk(clk), .rst(rst), .syscall(syscall), .breakc(breakc), .teq(teq), .zero(zero),
    .eret(eret), .pc(pc), .irq(irq), .status(status), .epc(epc), .stall(stall),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_w(input logic [4:0] a, input logic [31:0] d);
    q.push_back('{we: 1'b1, addr: a, data: d, rd: 1'b0, tgt: 32'd0, ack: 4'd0});
  endtask

  task automatic push_r(input logic [31:0] t, input logic [3:0] k);
    q.push_back('{we: 1'b0, addr: 5'd0, data: 32'd0, rd: 1'b1, tgt: t, ack: k});
  endtask

  task automatic push_exc(input logic [31:0] p, input logic [31:0] cause, input logic [31:0] st,
                          input logic [3:0] k);
    push_w(14, p);
    push_w(13, cause);
    push_w(12, st);
    push_r(32'h00400004, k);
  endtask

  // present one decode cycle, then check stall for the following n cycles and one idle cycle
  task automatic run(input string name, input logic sc, br, tq, z, input logic [3:0] ir,
                     input logic [31:0] st, p, input int n);
    @(posedge clk); #1;
    syscall = sc; breakc = br; teq = tq; zero = z; irq = ir; status = st; pc = p;
    @(negedge clk);
    chk({name, "_stall0"}, 76'(stall), 76'(n > 0));
    @(posedge clk); #1;
    syscall = 0; breakc = 0; teq = 0; zero = 0; irq = 0;
    for (int i = 1; i <= n + 1; i++) begin
      @(negedge clk);
      chk($sformatf("%s_stall%0d", name, i), 76'(stall), 76'(i <= n));
    end
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (cp0_we || pc_redirect) begin
        a = '{we: cp0_we, addr: cp0_waddr, data: cp0_wdata, rd: pc_redirect, tgt: pc_target, ack: irq_ack};
        if (q.size() == 0) chk("unexpected_output", 76'(a), 76'(0));
        else begin
          e = q.pop_front();
          chk("sb_item", 76'(a), 76'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    chk("reset_outputs", {stall, cp0_we, cp0_waddr, cp0_wdata, pc_redirect, pc_target, irq_ack},
        76'd0);
    @(posedge clk); #1 rst = 0;

    push_exc(32'h00400120, 32'h20, 32'hF0, 4'b0000);
    run("syscall", 1, 0, 0, 0, 4'b0000, 32'h0F, 32'h00400120, 4);

    push_exc(32'h00400140, 32'h24, 32'hD0, 4'b0000);
    run("sys_masked_brk", 1, 1, 0, 0, 4'b0000, 32'h0D, 32'h00400140, 4);

    push_exc(32'h00400144, 32'h20, 32'hB0, 4'b0000);
    run("sys_over_brk", 1, 1, 0, 0, 4'b0000, 32'h0B, 32'h00400144, 4);

    push_exc(32'h00400300, 32'h200, 32'h10, 4'b0010);
    run("irq_0110", 0, 0, 0, 0, 4'b0110, 32'h01, 32'h00400300, 4);

    run("teq_nozero", 0, 0, 1, 0, 4'b0000, 32'h0F, 32'h00400400, 0);

    push_exc(32'h00400404, 32'h34, 32'hF0, 4'b0000);
    run("teq_zero", 0, 0, 1, 1, 4'b0000, 32'h0F, 32'h00400404, 4);

    run("irq_ge_off", 0, 0, 0, 0, 4'b1111, 32'h0E, 32'h00400408, 0);

    // eret with irq pending: eret first, then irq taken under popped Status
    push_w(12, 32'h0F);
    push_r(32'h00400120, 4'b0000);
    push_exc(32'h00400500, 32'h100, 32'hF0, 4'b0001);
    @(posedge clk); #1;
    eret = 1; irq = 4'b0001; status = 32'hF0; epc = 32'h00400120; pc = 32'h00400500;
    @(negedge clk); chk("eret_stall0", 76'(stall), 76'(1));
    @(posedge clk); #1 eret = 0;
    @(negedge clk); chk("eret_stall1", 76'(stall), 76'(1));
    @(posedge clk); #1 status = 32'h0F;
    @(negedge clk); chk("eret_stall2", 76'(stall), 76'(1));
    @(posedge clk); #1;
    @(negedge clk); chk("eret_irq_stall0", 76'(stall), 76'(1));
    @(posedge clk); #1 irq = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); chk($sformatf("eret_irq_stall%0d", i), 76'(stall), 76'(i <= 4));
    end

    // reset during S_CAUSE: only the EPC write completes
    push_w(14, 32'h00400600);
    @(posedge clk); #1;
    syscall = 1; status = 32'h0F; pc = 32'h00400600;
    @(posedge clk); #1 syscall = 0;
    @(posedge clk); #1 rst = 1;
    #1 chk("rst_mid_outputs",
           {stall, cp0_we, cp0_waddr, cp0_wdata, pc_redirect, pc_target, irq_ack}, 76'd0);
    @(posedge clk); #1 rst = 0;
    repeat (5) @(posedge clk);
    #1 chk("rst_mid_idle_stall", 76'(stall), 76'(0));
    chk("sb_empty", 76'(q.size()), 76'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
